// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared access-type encoding, arbiter state codes and grant one-hot values
// Contents:
//   mem_access_t   - bus request type (NONE/R/W/X), 2 bits
//   arb_state_t    - arbiter FSM states
//   ARB_GRANT_*    - one-hot grant vector values, bit n = master n
package bus_arbiter_pkg;
    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_R    = 2'd1,
        ACC_W    = 2'd2,
        ACC_X    = 2'd3
    } mem_access_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] ARB_GRANT_NONE = 2'b00;
    localparam logic [1:0] ARB_GRANT_M0   = 2'b01;
    localparam logic [1:0] ARB_GRANT_M1   = 2'b10;
endpackage

// File: rtl/bus_arbiter_watchdog.sv
// arb_watchdog: 16-bit slave-wait counter that flags a transfer the slave never acknowledges
// Ports:
//   clk, res  - clock, asynchronous active-high reset
//   clr_i     - clear counter (idle, completion or abort)
//   en_i      - owner is requesting and the slave is not ready
//   to_o      - counter has reached TIMEOUT while still waiting
module arb_watchdog #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clk,
    input  logic res,
    input  logic clr_i,
    input  logic en_i,
    output logic to_o
);
    logic [15:0] cnt_q, cnt_d;

    assign to_o = en_i && (cnt_q == 16'(TIMEOUT));

    always_comb cnt_d = clr_i ? 16'd0 : en_i ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk or posedge res)
        if (res) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter with lock hold and slave timeout abort
// Ports:
//   clk, res                 - clock, asynchronous active-high reset
//   m0_* / m1_*              - master request (addr, dataOut, accessType, io, lock) and
//                              response (dataIn, ready, error)
//   s_*                      - slave request (addr, dataOut, accessType, io) and response
//                              (dataIn, ready)
//   grant                    - one-hot bus owner, 2'b00 when idle
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_dataOut,
    input  mem_access_t m0_accessType,
    input  logic        m0_io,
    input  logic        m0_lock,
    output logic [31:0] m0_dataIn,
    output logic        m0_ready,
    output logic        m0_error,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_dataOut,
    input  mem_access_t m1_accessType,
    input  logic        m1_io,
    input  logic        m1_lock,
    output logic [31:0] m1_dataIn,
    output logic        m1_ready,
    output logic        m1_error,
    output logic [31:0] s_addr,
    output logic [31:0] s_dataOut,
    output mem_access_t s_accessType,
    output logic        s_io,
    input  logic [31:0] s_dataIn,
    input  logic        s_ready,
    output logic [1:0]  grant
);
    arb_state_t state_q, state_d;
    logic       rr_last_q, rr_last_d;
    logic       in_g0, in_g1, req0, req1, own_req, own_lock, rdy, to;

    assign in_g0    = state_q == S_GRANT0;
    assign in_g1    = state_q == S_GRANT1;
    assign req0     = m0_accessType != ACC_NONE;
    assign req1     = m1_accessType != ACC_NONE;
    assign own_req  = s_accessType != ACC_NONE;
    assign own_lock = in_g0 ? m0_lock : in_g1 && m1_lock;
    // s_ready counts only against a live request, so it is ignored in idle
    assign rdy      = s_ready && own_req;

    always_comb begin
        s_addr       = in_g0 ? m0_addr       : in_g1 ? m1_addr       : 32'd0;
        s_dataOut    = in_g0 ? m0_dataOut    : in_g1 ? m1_dataOut    : 32'd0;
        s_accessType = in_g0 ? m0_accessType : in_g1 ? m1_accessType : ACC_NONE;
        s_io         = in_g0 ? m0_io         : in_g1 && m1_io;
        grant        = in_g0 ? ARB_GRANT_M0  : in_g1 ? ARB_GRANT_M1  : ARB_GRANT_NONE;
        m0_dataIn    = in_g0 ? s_dataIn : 32'd0;
        m1_dataIn    = in_g1 ? s_dataIn : 32'd0;
        m0_ready     = in_g0 && rdy;
        m1_ready     = in_g1 && rdy;
        m0_error     = in_g0 && to;
        m1_error     = in_g1 && to;
    end

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        if (state_q == S_IDLE) begin
            if (req0 && (!req1 || rr_last_q)) state_d = S_GRANT0;
            else if (req1)                    state_d = S_GRANT1;
        end else if (rdy || to) begin
            // an abort ignores lock and hands priority to the other master
            rr_last_d = in_g1;
            state_d   = (rdy && own_lock) ? state_q : S_IDLE;
        end else if (!own_req && !own_lock) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge res)
        if (res) begin
            state_q   <= S_IDLE;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
        end

    // timeout needs s_ready low, so a coinciding ready always completes normally
    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk   (clk),
        .res   (res),
        .clr_i (state_q == S_IDLE || rdy || to),
        .en_i  (own_req && !s_ready),
        .to_o  (to)
    );
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table-driven and scoreboard-checked bench for bus_arbiter
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int TO = 4;

    typedef struct {
        int          m;
        mem_access_t acc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        io;
        logic        lock;
        int          lat;
        logic        err;
    } job_t;

    typedef struct {
        mem_access_t acc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        io;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        res;
    logic [31:0] m0_addr, m0_dataOut, m0_dataIn, m1_addr, m1_dataOut, m1_dataIn;
    mem_access_t m0_accessType, m1_accessType, s_accessType;
    logic        m0_io, m0_lock, m0_ready, m0_error, m1_io, m1_lock, m1_ready, m1_error;
    logic [31:0] s_addr, s_dataOut, s_dataIn;
    logic        s_io, s_ready;
    logic [1:0]  grant;

    job_t        jq[2][$];
    exp_t        sb[2][$];
    job_t        cur[2];
    logic        act[2];
    logic        done[2];
    logic        timed;
    int          cyc;
    int          scnt;
    int          n_chk, n_pass;
    logic [1:0]  gtr[$];
    int          gcnt[4];
    exp_t        mon_e;
    job_t        vt[7];

    bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .res(res),
        .m0_addr(m0_addr), .m0_dataOut(m0_dataOut), .m0_accessType(m0_accessType),
        .m0_io(m0_io), .m0_lock(m0_lock), .m0_dataIn(m0_dataIn), .m0_ready(m0_ready),
        .m0_error(m0_error),
        .m1_addr(m1_addr), .m1_dataOut(m1_dataOut), .m1_accessType(m1_accessType),
        .m1_io(m1_io), .m1_lock(m1_lock), .m1_dataIn(m1_dataIn), .m1_ready(m1_ready),
        .m1_error(m1_error),
        .s_addr(s_addr), .s_dataOut(s_dataOut), .s_accessType(s_accessType), .s_io(s_io),
        .s_dataIn(s_dataIn), .s_ready(s_ready), .grant(grant)
    );

    always #5 clk = ~clk;

    assign m0_addr       = cur[0].addr;
    assign m0_dataOut    = cur[0].wdata;
    assign m0_io         = cur[0].io;
    assign m0_lock       = act[0] & cur[0].lock;
    assign m0_accessType = act[0] ? cur[0].acc : ACC_NONE;
    assign m1_addr       = cur[1].addr;
    assign m1_dataOut    = cur[1].wdata;
    assign m1_io         = cur[1].io;
    assign m1_lock       = act[1] & cur[1].lock;
    assign m1_accessType = act[1] ? cur[1].acc : ACC_NONE;

    function automatic logic [31:0] sd(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic trace(input int n);
        logic [1:0] last;
        gtr.delete();
        for (int i = 0; i < 4; i++) gcnt[i] = 0;
        last = 2'b11;
        repeat (n) begin
            tick();
            gcnt[grant]++;
            if (grant != last) gtr.push_back(grant);
            last = grant;
        end
    endtask

    task automatic chk_trace(input string nm, input logic [1:0] want[]);
        chk({nm, "_len"}, gtr.size(), want.size());
        for (int i = 0; i < want.size() && i < gtr.size(); i++)
            chk($sformatf("%s_%0d", nm, i), {30'd0, gtr[i]}, {30'd0, want[i]});
    endtask

    task automatic push(input job_t j);
        jq[j.m].push_back(j);
    endtask

    always @(posedge clk) cyc++;

    // masters: pick up the next queued job once the previous one has finished
    always @(posedge clk) begin
        #1;
        for (int n = 0; n < 2; n++) begin
            if (act[n] && done[n]) act[n] = 1'b0;
            done[n] = 1'b0;
            if (!act[n] && jq[n].size() != 0 && !res) begin
                cur[n] = jq[n].pop_front();
                act[n] = 1'b1;
                sb[n].push_back('{cur[n].acc, cur[n].addr, cur[n].wdata, cur[n].io, cur[n].err,
                                  cur[n].err ? 32'd0 : sd(cur[n].addr),
                                  timed ? cyc + 1 + (cur[n].lat < TO ? cur[n].lat : TO) : -1});
            end
        end
    end

    // slave: acknowledges the forwarded request after the owner job's latency
    always @(posedge clk) begin
        #2;
        if (res || s_accessType == ACC_NONE) begin
            s_ready  = 1'b0;
            s_dataIn = 32'd0;
            scnt     = 0;
        end else if (scnt == (grant[1] ? cur[1].lat : cur[0].lat)) begin
            s_ready  = 1'b1;
            s_dataIn = sd(s_addr);
            scnt     = 0;
        end else begin
            s_ready  = 1'b0;
            s_dataIn = 32'd0;
            scnt++;
        end
    end

    // scoreboard: each ready/error pulse is compared against the oldest expectation
    always @(negedge clk) begin
        if (!res) begin
            for (int n = 0; n < 2; n++) begin
                logic r, e, ro;
                logic [31:0] d, dout;
                r    = n ? m1_ready : m0_ready;
                e    = n ? m1_error : m0_error;
                d    = n ? m1_dataIn : m0_dataIn;
                ro   = n ? m0_ready : m1_ready;
                dout = n ? m0_dataIn : m1_dataIn;
                if (r || e) begin
                    done[n] = 1'b1;
                    chk($sformatf("m%0d_expected_pulse", n), sb[n].size() != 0, 1);
                    chk($sformatf("m%0d_other_ready", n), ro, 0);
                    chk($sformatf("m%0d_other_dataIn", n), dout, 0);
                    if (sb[n].size() != 0) begin
                        mon_e = sb[n].pop_front();
                        chk($sformatf("m%0d_error", n), e, mon_e.err);
                        chk($sformatf("m%0d_ready", n), r, !mon_e.err);
                        chk($sformatf("m%0d_dataIn", n), d, mon_e.rdata);
                        chk($sformatf("m%0d_s_addr", n), s_addr, mon_e.addr);
                        chk($sformatf("m%0d_s_accessType", n), s_accessType, mon_e.acc);
                        chk($sformatf("m%0d_s_dataOut", n), s_dataOut, mon_e.wdata);
                        chk($sformatf("m%0d_s_io", n), s_io, mon_e.io);
                        if (mon_e.cyc >= 0) chk($sformatf("m%0d_done_cycle", n), cyc, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string nm);
        int b;
        b = 0;
        while ((act[0] || act[1] || sb[0].size() != 0 || sb[1].size() != 0 ||
                jq[0].size() != 0 || jq[1].size() != 0) && b < 60) begin
            tick();
            b++;
        end
        chk({nm, "_drained"}, b < 60, 1);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_grant"}, grant, 2'b00);
        chk({nm, "_rdy_err"}, {m0_ready, m0_error, m1_ready, m1_error}, 4'b0);
        chk({nm, "_m0_dataIn"}, m0_dataIn, 0);
        chk({nm, "_m1_dataIn"}, m1_dataIn, 0);
        chk({nm, "_s_accessType"}, s_accessType, ACC_NONE);
        chk({nm, "_s_addr"}, s_addr, 0);
        chk({nm, "_s_dataOut"}, s_dataOut, 0);
        chk({nm, "_s_io"}, s_io, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        cyc = 0;
        timed = 1'b0;
        s_ready = 1'b0;
        s_dataIn = 32'd0;
        scnt = 0;
        for (int n = 0; n < 2; n++) begin
            cur[n] = '{0, ACC_NONE, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1'b0};
            act[n] = 1'b0;
            done[n] = 1'b0;
        end
        vt[0] = '{0, ACC_R, 32'h0000_0100, 32'h0,         1'b0, 1'b0, 2,   1'b0};
        vt[1] = '{1, ACC_W, 32'h0000_2000, 32'h1234_5678, 1'b1, 1'b0, 0,   1'b0};
        vt[2] = '{0, ACC_X, 32'h0000_0300, 32'h0,         1'b0, 1'b0, 1,   1'b0};
        vt[3] = '{1, ACC_R, 32'h0000_0400, 32'h0,         1'b1, 1'b0, 3,   1'b0};
        vt[4] = '{0, ACC_W, 32'h0000_0500, 32'hCAFE_F00D, 1'b0, 1'b0, TO,  1'b0};
        vt[5] = '{1, ACC_X, 32'h0000_0600, 32'h0,         1'b0, 1'b0, 200, 1'b1};
        vt[6] = '{0, ACC_R, 32'h0000_0700, 32'h0,         1'b1, 1'b0, 200, 1'b1};

        res = 1'b1;
        repeat (3) tick();
        chk_reset_outputs("in_reset");
        res = 1'b0;
        tick();
        chk_reset_outputs("after_reset");

        // both masters request out of reset: m0 first, then alternate with idle bubbles
        push('{0, ACC_R, 32'h1000, 32'h0, 1'b0, 1'b0, 1, 1'b0});
        push('{0, ACC_R, 32'h1004, 32'h0, 1'b0, 1'b0, 1, 1'b0});
        push('{1, ACC_R, 32'h2000, 32'h0, 1'b0, 1'b0, 1, 1'b0});
        push('{1, ACC_R, 32'h2004, 32'h0, 1'b0, 1'b0, 1, 1'b0});
        trace(16);
        chk_trace("rr_alt", '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00});
        wait_idle("rr_alt");

        // read-modify-write under lock while m1 waits
        push('{0, ACC_R, 32'h204, 32'h0,  1'b0, 1'b1, 1, 1'b0});
        push('{0, ACC_W, 32'h204, 32'hAB, 1'b0, 1'b0, 1, 1'b0});
        push('{1, ACC_R, 32'h3000, 32'h0, 1'b1, 1'b0, 1, 1'b0});
        trace(10);
        chk_trace("rmw", '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00});
        chk("rmw_grant0_cycles", gcnt[1], 4);
        wait_idle("rmw");

        // single-master vectors with exact latency and completion timing
        timed = 1'b1;
        for (int i = 0; i < 7; i++) begin
            push(vt[i]);
            tick();
            chk($sformatf("vec%0d_grant_latency", i), grant, 2'b00);
            tick();
            chk($sformatf("vec%0d_grant", i), grant, vt[i].m ? 2'b10 : 2'b01);
            chk($sformatf("vec%0d_s_addr", i), s_addr, vt[i].addr);
            wait_idle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_grant_after", i), grant, 2'b00);
        end
        timed = 1'b0;

        // timeout on m1 with m0 pending: m0 granted right after the abort bubble
        push('{1, ACC_X, 32'h600, 32'h0, 1'b0, 1'b0, 200, 1'b1});
        tick();
        push('{0, ACC_R, 32'h700, 32'h0, 1'b0, 1'b0, 1, 1'b0});
        trace(10);
        chk_trace("to_pending", '{2'b10, 2'b00, 2'b01, 2'b00});
        chk("to_grant1_cycles", gcnt[2], TO + 1);
        wait_idle("to_pending");

        // asynchronous reset while m1 write waits on the slave
        push('{1, ACC_W, 32'h800, 32'h5555_AAAA, 1'b1, 1'b0, 200, 1'b0});
        repeat (3) tick();
        chk("mid_grant", grant, 2'b10);
        chk("mid_s_dataOut", s_dataOut, 32'h5555_AAAA);
        #1;
        res = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        jq[0].delete();
        jq[1].delete();
        sb[0].delete();
        sb[1].delete();
        act[0] = 1'b0;
        act[1] = 1'b0;
        tick();
        tick();
        res = 1'b0;
        push('{0, ACC_R, 32'h900, 32'h0, 1'b0, 1'b0, 1, 1'b0});
        push('{1, ACC_R, 32'hA00, 32'h0, 1'b0, 1'b0, 1, 1'b0});
        trace(10);
        chk_trace("post_reset", '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00});
        wait_idle("post_reset");

        chk("sb0_empty", sb[0].size(), 0);
        chk("sb1_empty", sb[1].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter for the physical data bus.
- Shares the memory/IO slave between master 0 (the CPU_MMU bus side: CPU with address translation) and master 1 (a DMA/display fetch engine).
- Uses round-robin priority.
- Holds the bus across a master's read-modify-write sequence via a lock input.
- A watchdog aborts transfers the slave never acknowledges.

Parameters:
- TAG, "bus_arbiter", debug display prefix.
- TIMEOUT, 1023, slave wait cycles before abort (1..65535).

Ports:
- clk input 1: system clock.
- res input 1: reset, asynchronous, active-high.
- m0_addr input 32: master 0 physical address.
- m0_dataOut input 32: master 0 write data.
- m0_accessType input `MEM_ACCESS: master 0 request (NONE/R/W/X, encoding from DataBus.vh).
- m0_io input 1: master 0 IO (uncached) access.
- m0_lock input 1: keep grant after the current transfer.
- m0_dataIn output 32: read data to master 0.
- m0_ready output 1: transfer done for master 0.
- m0_error output 1: timeout abort for master 0.
- m1_addr, m1_dataOut, m1_accessType, m1_io, m1_lock, m1_dataIn, m1_ready, m1_error: same as master 0, for master 1.
- s_addr output 32: slave address.
- s_dataOut output 32: slave write data.
- s_accessType output `MEM_ACCESS: slave request.
- s_io output 1: slave IO flag.
- s_dataIn input 32: slave read data.
- s_ready input 1: slave done.
- grant output 2: one-hot owner, bit n = master n; 2'b00 when idle.

Behaviour:
- A master requests while accessType != NONE. It holds addr, dataOut, accessType and io stable until its ready or error pulses.
- States:
  - S_IDLE: grant 00; s_accessType NONE.
  - S_GRANT0, S_GRANT1: the owner's addr, dataOut, accessType and io are forwarded combinationally to s_*.
- S_IDLE transitions:
  - Only one master requesting: grant it next cycle.
  - Both requesting: grant the master not served last (rrLast register, reset value 1, so master 0 wins first).
  - Arbitration latency is 1 cycle: a request in IDLE at cycle t is on s_* at t+1.
- S_GRANTn:
  - s_dataIn is routed to mn_dataIn every cycle. The non-owner's dataIn reads 32'd0.
  - mn_ready = s_ready && s_accessType != NONE. The non-owner's ready is always 0.
- Completion (mn_ready = 1):
  - rrLast <= n.
  - If mn_lock = 1 in that cycle, stay in S_GRANTn. A new request from the owner is forwarded the next cycle with no bubble.
  - Otherwise go to S_IDLE, giving a one-cycle bubble between different-owner transfers.
- Owner in S_GRANTn with accessType NONE:
  - lock = 1: hold the grant, with no timeout counting.
  - lock = 0: go to S_IDLE next cycle.
- Watchdog (16-bit counter):
  - Clears on entry to S_GRANTn and on every completion.
  - Increments each cycle the owner requests and s_ready = 0.
  - Timeout condition: counter reaches TIMEOUT with s_ready still 0.
  - On timeout, pulse mn_error for 1 cycle (mn_ready stays 0) and force S_IDLE. Lock is ignored, and rrLast <= n so the other master gets priority.
- s_ready while in S_IDLE is ignored.
- Simultaneous timeout and s_ready in the same cycle: s_ready wins and the transfer completes normally.
- Requester withdrawal (illegal for masters): the arbiter must still not hang; the lock = 0 IDLE rule above covers it.
- Reset (any time, including mid-transfer):
  - State S_IDLE, grant 00, rrLast 1, counter 0.
  - All mn_ready/mn_error 0, mn_dataIn 0.
  - s_accessType NONE, s_addr 0, s_dataOut 0, s_io 0.
  - An interrupted transfer is simply dropped; masters are reset by the same res.
- Under DEBUG_DISPLAY: $display on each grant change and each timeout, prefixed by TAG.

Decomposition:
- `MEM_ACCESS width and encodings come from DataBus.vh.
- Arbiter state codes and the ARB_GRANT_* one-hot values go in a new bus_arbiter.vh.
- One natural sub-module: arb_watchdog (counter, clear/enable inputs, timeout output, TIMEOUT parameter).
- The mux, round-robin logic and FSM stay in bus_arbiter.

Test Plan:
- m0 R at 0x100 alone, slave ready after 2 cycles with data 0xDEADBEEF:
  - grant = 01 one cycle after the request; s_addr = 0x100; m0_dataIn = 0xDEADBEEF with m0_ready pulsed; m1_ready stays 0.
- m0 and m1 both request out of reset:
  - m0 served first, then IDLE for 1 cycle, then m1.
  - Repeating both requests alternates grant 01, 00, 10, 00, 01.
- m0 byte-write RMW (R then W at 0x204) with m0_lock = 1 on the read completion while m1 is requesting:
  - The W is forwarded the cycle after the read's ready, with grant held at 01.
  - m1 is granted only after the W completes with lock = 0.
- TIMEOUT = 4, m1 X request, s_ready held 0:
  - m1_error pulses exactly once, 4 cycles after the grant; grant returns to 00.
  - If m0 is pending, it is granted next.
- s_ready and timeout coincide: ready is given, no error.
- res asserted mid-transfer (m1 W granted, slave waiting): all outputs return to reset values immediately (asynchronously); after release, m0 wins the first simultaneous arbitration.
